vec_mac_engine: RTL and testbench

Multi-lane dot-product MAC for the ViT accelerator datapath. It succeeds the single-lane MAC with parametrised lane count and accumulator width, and adds a valid/ready handshake, grouped accumulation framed by `in_last`, and round/shift/saturate output scaling. It sits between the operand fetch buffers and the activation/writeback stage, and produces one scaled result per accumulation group.

---
 rtl/vec_mac_engine.sv | 184 ++++++++++++++++++
 tb/tb_vec_mac_engine.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/vec_mac_engine.sv
// Multi-lane signed dot-product MAC with grouped accumulation framed by in_last,
// valid/ready handshakes and round/shift/saturate output scaling.
module vec_mac_engine #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned LANES      = 4,
    parameter int unsigned ACC_WIDTH  = 40,
    parameter int unsigned OUT_WIDTH  = 16,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES*DATA_WIDTH-1:0]   in_a,
    input  logic [LANES*DATA_WIDTH-1:0]   in_b,
    input  logic                          in_last,
    input  logic [5:0]                    in_shift,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OUT_WIDTH-1:0]          out_data,
    output logic [ACC_WIDTH-1:0]          out_acc,
    output logic                          out_sat,
    output logic [CNT_WIDTH-1:0]          out_beats
);
    localparam int unsigned PROD_W  = 2 * DATA_WIDTH;
    localparam int unsigned EXT_W   = ACC_WIDTH + 1;
    localparam int unsigned SHIFT_W = 6;
    localparam logic signed [EXT_W-1:0] OUT_MAX =
        {{(EXT_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] OUT_MIN = ~OUT_MAX;

    typedef enum logic [1:0] {ACCUM, DRAIN, HOLD} state_t;

    state_t                  state, state_next;
    logic [1:0]              drain_cnt, drain_next;
    logic                    accept_c, handshake_c;

    logic                    group_first;
    logic [SHIFT_W-1:0]      shift_q;
    logic [CNT_WIDTH-1:0]    beat_cnt;

    logic signed [PROD_W-1:0]    s1_prod [LANES];
    logic                        s1_valid, s1_last, s1_first;
    logic signed [ACC_WIDTH-1:0] sum_c, s2_sum;
    logic                        s2_valid, s2_last, s2_first;
    logic signed [ACC_WIDTH-1:0] acc;
    logic                        s3_valid, s3_last;

    logic [SHIFT_W-1:0]          s_c;
    logic signed [EXT_W-1:0]     acc_ext_c, rnd_c, r_c;
    logic                        sat_c;
    logic [OUT_WIDTH-1:0]        data_c;

    assign accept_c    = in_valid && in_ready;
    assign handshake_c = out_valid && out_ready;

    // Control state register plus registered handshake flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACCUM;
            drain_cnt <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_next;
            drain_cnt <= drain_next;
            in_ready  <= (state_next == ACCUM);
            out_valid <= (state_next == HOLD);
        end
    end

    always_comb begin
        state_next = state;
        drain_next = drain_cnt;
        case (state)
            ACCUM: if (accept_c && in_last) begin
                state_next = DRAIN;
                drain_next = '0;
            end
            DRAIN: if (drain_cnt == 2'd3) state_next = HOLD;
                   else drain_next = drain_cnt + 2'd1;
            HOLD:  if (handshake_c) state_next = ACCUM;
            default: state_next = ACCUM;
        endcase
    end

    // Per-group bookkeeping: first-beat flag, shift amount, saturating beat count
    always_ff @(posedge clk) begin
        if (rst) begin
            group_first <= 1'b1;
            shift_q     <= '0;
            beat_cnt    <= '0;
        end else begin
            if (accept_c) begin
                group_first <= 1'b0;
                if (group_first) begin
                    shift_q  <= in_shift;
                    beat_cnt <= CNT_WIDTH'(1);
                end else if (!(&beat_cnt)) begin
                    beat_cnt <= beat_cnt + CNT_WIDTH'(1);
                end
            end
            if (handshake_c) group_first <= 1'b1;
        end
    end

    // Pipeline valid/framing flags
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0; s1_last <= 1'b0; s1_first <= 1'b0;
            s2_valid <= 1'b0; s2_last <= 1'b0; s2_first <= 1'b0;
            s3_valid <= 1'b0; s3_last <= 1'b0;
        end else begin
            s1_valid <= accept_c;
            s1_last  <= in_last;
            s1_first <= group_first;
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            s2_first <= s1_first;
            s3_valid <= s2_valid;
            s3_last  <= s2_last;
        end
    end

    // S1 lane products
    always_ff @(posedge clk) begin
        if (accept_c) begin
            for (int i = 0; i < LANES; i++) begin
                s1_prod[i] <= PROD_W'($signed(in_a[i*DATA_WIDTH +: DATA_WIDTH]))
                            * PROD_W'($signed(in_b[i*DATA_WIDTH +: DATA_WIDTH]));
            end
        end
    end

    always_comb begin
        sum_c = '0;
        for (int i = 0; i < LANES; i++) begin
            sum_c = sum_c + ACC_WIDTH'(s1_prod[i]);
        end
    end

    // S2 lane sum and S3 wrapping accumulator
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_sum <= '0;
            acc    <= '0;
        end else begin
            s2_sum <= sum_c;
            if (s2_valid) acc <= s2_first ? s2_sum : acc + s2_sum;
        end
    end

    // Rounding shift at one extra bit so the rounding add never wraps
    always_comb begin
        s_c       = (32'(shift_q) > ACC_WIDTH - 1) ? SHIFT_W'(ACC_WIDTH - 1) : shift_q;
        acc_ext_c = EXT_W'(acc);
        rnd_c     = (s_c == '0) ? '0 : (EXT_W'(1) << (s_c - 6'd1));
        r_c       = (acc_ext_c + rnd_c) >>> s_c;
        sat_c     = 1'b0;
        data_c    = r_c[OUT_WIDTH-1:0];
        if (r_c > OUT_MAX) begin
            sat_c  = 1'b1;
            data_c = OUT_MAX[OUT_WIDTH-1:0];
        end else if (r_c < OUT_MIN) begin
            sat_c  = 1'b1;
            data_c = OUT_MIN[OUT_WIDTH-1:0];
        end
    end

    // S4 output register, loaded only by the group's last beat
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_acc   <= '0;
            out_sat   <= 1'b0;
            out_beats <= '0;
        end else if (s3_valid && s3_last) begin
            out_data  <= data_c;
            out_acc   <= acc;
            out_sat   <= sat_c;
            out_beats <= beat_cnt;
        end
    end
endmodule

// File: tb/tb_vec_mac_engine.sv
// Scoreboard bench for vec_mac_engine: default instance plus a CNT_WIDTH=2 twin
// driven in lockstep so beat-count saturation is exercised on every group.
module tb_vec_mac_engine;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_last, out_ready;
    logic [63:0] in_a, in_b;
    logic [5:0]  in_shift;
    logic        in_ready, out_valid, out_sat;
    logic [15:0] out_data;
    logic [39:0] out_acc;
    logic [7:0]  out_beats;
    logic        in_ready2, out_valid2, out_sat2;
    logic [15:0] out_data2;
    logic [39:0] out_acc2;
    logic [1:0]  out_beats2;

    int checks = 0;
    int failures = 0;

    typedef struct {
        longint data;
        longint acc;
        longint sat;
        longint beats;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    vec_mac_engine dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .in_shift(in_shift),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_acc(out_acc), .out_sat(out_sat), .out_beats(out_beats)
    );

    vec_mac_engine #(.CNT_WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .in_shift(in_shift),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
        .out_acc(out_acc2), .out_sat(out_sat2), .out_beats(out_beats2)
    );

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
        end
    endtask

    function automatic logic [63:0] pack4(input int x0, input int x1, input int x2, input int x3);
        return {16'(x3), 16'(x2), 16'(x1), 16'(x0)};
    endfunction

    task automatic expect_result(input longint d, input longint a, input longint s, input longint b);
        exp_t e;
        e.data = d; e.acc = a; e.sat = s; e.beats = b;
        exp_q.push_back(e);
    endtask

    // Offer one beat from a negedge; returns at the negedge after acceptance
    task automatic drive_beat(input logic [63:0] a, input logic [63:0] b,
                              input logic last, input logic [5:0] sh);
        int n = 0;
        in_a = a; in_b = b; in_last = last; in_shift = sh; in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("beat_accept_timeout", 0, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_out_valid(input string name);
        int n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk(name, 0, 1);
    endtask

    // Monitor: compare every result handshake against the scoreboard head
    always @(negedge clk) begin
        #1;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_data", longint'($signed(out_data)), e.data);
                chk("out_acc", longint'($signed(out_acc)), e.acc);
                chk("out_sat", longint'(out_sat), e.sat);
                chk("out_beats", longint'(out_beats), e.beats);
                chk("out_beats_cnt2", longint'(out_beats2), (e.beats > 3) ? 3 : e.beats);
                chk("out_data_cnt2", longint'($signed(out_data2)), e.data);
            end
        end
    end

    logic [63:0] a1, b1, an, amax, amin, aone, bone;

    initial begin
        a1   = pack4(1, 2, 3, 4);
        b1   = pack4(5, 6, 7, 8);
        an   = pack4(-1, -2, -3, -4);
        amax = pack4(32767, 32767, 32767, 32767);
        amin = pack4(-32768, -32768, -32768, -32768);
        aone = pack4(1, 0, 0, 0);
        bone = pack4(1, 0, 0, 0);

        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_shift = '0;
        in_a = '0; in_b = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", longint'(in_ready), 0);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_out_data", longint'(out_data), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", longint'(in_ready), 1);

        // Single-beat group with latency check
        expect_result(70, 70, 0, 1);
        drive_beat(a1, b1, 1'b1, 6'd0);
        repeat (3) @(negedge clk);
        chk("latency_e3_invalid", longint'(out_valid), 0);
        @(negedge clk);
        chk("latency_e4_valid", longint'(out_valid), 1);
        idle(2);

        // Three beats with bubbles
        expect_result(210, 210, 0, 3);
        drive_beat(a1, b1, 1'b0, 6'd0); idle(2);
        drive_beat(a1, b1, 1'b0, 6'd7); idle(1);
        drive_beat(a1, b1, 1'b1, 6'd0);
        idle(8);

        // Rounded shifts, positive and negative
        expect_result(9, 70, 0, 1);
        drive_beat(a1, b1, 1'b1, 6'd3);
        idle(8);
        expect_result(-9, -70, 0, 1);
        drive_beat(an, b1, 1'b1, 6'd3);
        idle(8);

        // Saturation both ways
        expect_result(32767, 64'sd8589410312, 1, 2);
        drive_beat(amax, amax, 1'b0, 6'd0);
        drive_beat(amax, amax, 1'b1, 6'd0);
        idle(8);
        expect_result(-32768, -64'sd8589672448, 1, 2);
        drive_beat(amin, amax, 1'b0, 6'd0);
        drive_beat(amin, amax, 1'b1, 6'd0);
        idle(8);

        // Backpressure: result held, offered beats refused
        out_ready = 1'b0;
        expect_result(70, 70, 0, 1);
        drive_beat(a1, b1, 1'b1, 6'd0);
        wait_out_valid("bp_out_valid_timeout");
        in_a = amax; in_b = amax; in_last = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            chk("bp_out_valid", longint'(out_valid), 1);
            chk("bp_in_ready", longint'(in_ready), 0);
            chk("bp_out_data", longint'($signed(out_data)), 70);
            @(negedge clk);
        end
        in_valid = 1'b0; in_last = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_in_ready_after_hs", longint'(in_ready), 1);
        chk("bp_out_valid_after_hs", longint'(out_valid), 0);
        expect_result(70, 70, 0, 1);
        drive_beat(a1, b1, 1'b1, 6'd0);
        idle(8);

        // Reset mid-group discards in-flight beats
        drive_beat(amax, amax, 1'b0, 6'd0);
        drive_beat(amax, amax, 1'b0, 6'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", longint'(in_ready), 0);
        chk("midrst_out_valid", longint'(out_valid), 0);
        chk("midrst_out_data", longint'(out_data), 0);
        chk("midrst_out_acc", longint'(out_acc), 0);
        chk("midrst_out_sat", longint'(out_sat), 0);
        chk("midrst_out_beats", longint'(out_beats), 0);
        rst = 1'b0;
        expect_result(70, 70, 0, 1);
        drive_beat(a1, b1, 1'b1, 6'd0);
        idle(8);

        // Five beats: twin instance's 2-bit beat count saturates at 3
        expect_result(5, 5, 0, 5);
        for (int k = 0; k < 5; k++) drive_beat(aone, bone, (k == 4), 6'd0);
        idle(8);

        for (int n = 0; n < 100 && exp_q.size() != 0; n++) @(negedge clk);
        if (exp_q.size() != 0) chk("results_pending", longint'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
